// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - multi-entry register bank with op-encoded write port, two registered read ports and a shadow bank
module reg_bank #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               BYPASS      = 1'b1,
    localparam int              ADDR_W      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WE,
    input  logic [1:0]        OP,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [WIDTH-1:0]  OUT_A,
    output logic [WIDTH-1:0]  OUT_B,
    input  logic              SAVE,
    input  logic              RESTORE
);

    // Write operation encodings.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Declaration initialisers give the same contents at power-up as after RESET.
    logic [WIDTH-1:0] bank_q   [DEPTH] = '{default: RESET_VALUE};
    logic [WIDTH-1:0] shadow_q [DEPTH] = '{default: RESET_VALUE};
    logic [WIDTH-1:0] out_a_q          = RESET_VALUE;
    logic [WIDTH-1:0] out_b_q          = RESET_VALUE;

    logic [WIDTH-1:0] bank_d   [DEPTH];
    logic [WIDTH-1:0] shadow_d [DEPTH];
    logic [WIDTH-1:0] out_a_d;
    logic [WIDTH-1:0] out_b_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_data;

    // Fetch the current value of the addressed entry and compute the op result.
    // An out-of-range WADDR matches no entry, so the write simply never lands.
    always_comb begin
        wr_cur  = '0;
        wr_data = '0;
        wr_en   = WE && !RESTORE;
        for (int i = 0; i < DEPTH; i++) begin
            if (WADDR == ADDR_W'(i)) begin
                wr_cur = bank_q[i];
            end
        end
        case (OP)
            OP_LOAD: wr_data = IN;
            OP_INC:  wr_data = wr_cur + WIDTH'(1);
            OP_DEC:  wr_data = wr_cur - WIDTH'(1);
            OP_CLR:  wr_data = '0;
            default: wr_data = '0;
        endcase
    end

    // Next bank/shadow contents: RESTORE overrides the write; SAVE samples the
    // pre-edge bank so SAVE+RESTORE together swap the two banks.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bank_d[i]   = bank_q[i];
            shadow_d[i] = shadow_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (RESTORE) begin
                bank_d[i] = shadow_q[i];
            end else if (wr_en && (WADDR == ADDR_W'(i))) begin
                bank_d[i] = wr_data;
            end
            if (SAVE) begin
                shadow_d[i] = bank_q[i];
            end
        end
    end

    // Read ports: post-update contents when bypassing, pre-edge contents
    // otherwise; addresses beyond the bank read as zero.
    always_comb begin
        out_a_d = '0;
        out_b_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RADDR_A == ADDR_W'(i)) begin
                out_a_d = BYPASS ? bank_d[i] : bank_q[i];
            end
            if (RADDR_B == ADDR_W'(i)) begin
                out_b_d = BYPASS ? bank_d[i] : bank_q[i];
            end
        end
    end

    // State register with synchronous reset that discards every same-edge operation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i]   <= RESET_VALUE;
                shadow_q[i] <= RESET_VALUE;
            end
            out_a_q <= RESET_VALUE;
            out_b_q <= RESET_VALUE;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i]   <= bank_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign OUT_A = out_a_q;
    assign OUT_B = out_b_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - scoreboard bench for reg_bank with bypass and non-bypass instances
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [2:0]  waddr = '0;
    logic [15:0] din = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [15:0] out_a1, out_b1, out_a0, out_b0;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] a1;
        logic [15:0] b1;
        logic [15:0] a0;
        logic [15:0] b0;
    } exp_t;

    exp_t sb[$];

    reg_bank #(.WIDTH(16), .DEPTH(6), .RESET_VALUE(16'h00A5), .BYPASS(1'b1)) u_byp (
        .CLK(clk), .RESET(reset), .WE(we), .OP(op), .WADDR(waddr), .IN(din),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b), .OUT_A(out_a1), .OUT_B(out_b1),
        .SAVE(save), .RESTORE(restore)
    );

    reg_bank #(.WIDTH(16), .DEPTH(6), .RESET_VALUE(16'h00A5), .BYPASS(1'b0)) u_nobyp (
        .CLK(clk), .RESET(reset), .WE(we), .OP(op), .WADDR(waddr), .IN(din),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b), .OUT_A(out_a0), .OUT_B(out_b0),
        .SAVE(save), .RESTORE(restore)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input string port, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h expected %h", name, port, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare whatever is due this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, "byp.OUT_A", out_a1, e.a1);
            check(e.name, "byp.OUT_B", out_b1, e.b1);
            check(e.name, "nobyp.OUT_A", out_a0, e.a0);
            check(e.name, "nobyp.OUT_B", out_b0, e.b0);
        end
    end

    task automatic step(input string name,
                        input logic w, input logic [1:0] o, input logic [2:0] wa, input logic [15:0] d,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic sv, input logic rs, input logic rst,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic [15:0] a0, input logic [15:0] b0);
        exp_t e;
        we = w; op = o; waddr = wa; din = d;
        raddr_a = ra; raddr_b = rb;
        save = sv; restore = rs; reset = rst;
        e.cyc = cycle + 1;
        e.name = name;
        e.a1 = a1; e.b1 = b1; e.a0 = a0; e.b0 = b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic [15:0] a0, input logic [15:0] b0);
        step(name, 1'b0, 2'b00, 3'd0, 16'h0000, ra, rb, 1'b0, 1'b0, 1'b0, a1, b1, a0, b0);
    endtask

    logic [15:0] final_vals [6];

    initial begin
        final_vals = '{16'h1111, 16'h0011, 16'h0022, 16'h1234, 16'h00A5, 16'h0000};

        step("reset", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 0, 0, 1, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);
        for (int i = 0; i < 6; i++)
            idle("init_read", 3'(i), 3'(5 - i), 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);

        // Load latency and bypass behaviour.
        step("load3", 1, 2'b00, 3'd3, 16'h1234, 3'd3, 3'd0, 0, 0, 0, 16'h1234, 16'h00A5, 16'h00A5, 16'h00A5);
        idle("load3_next", 3'd3, 3'd0, 16'h1234, 16'h00A5, 16'h1234, 16'h00A5);

        // Increment/decrement wrap and clear on reg 5.
        step("load5_ffff", 1, 2'b00, 3'd5, 16'hFFFF, 3'd5, 3'd3, 0, 0, 0, 16'hFFFF, 16'h1234, 16'h00A5, 16'h1234);
        step("inc_wrap",   1, 2'b01, 3'd5, 16'h0,    3'd5, 3'd3, 0, 0, 0, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234);
        step("dec_wrap",   1, 2'b10, 3'd5, 16'h0,    3'd5, 3'd3, 0, 0, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234);
        step("load5_zero", 1, 2'b00, 3'd5, 16'h0,    3'd5, 3'd3, 0, 0, 0, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234);
        step("clr_zero",   1, 2'b11, 3'd5, 16'h0,    3'd5, 3'd3, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h1234);
        step("load5_beef", 1, 2'b00, 3'd5, 16'hBEEF, 3'd5, 3'd3, 0, 0, 0, 16'hBEEF, 16'h1234, 16'h0000, 16'h1234);
        step("clr_beef",   1, 2'b11, 3'd5, 16'h5A5A, 3'd5, 3'd3, 0, 0, 0, 16'h0000, 16'h1234, 16'hBEEF, 16'h1234);
        idle("clr_hold", 3'd5, 3'd3, 16'h0000, 16'h1234, 16'h0000, 16'h1234);

        // Dual read ports.
        step("wr1", 1, 2'b00, 3'd1, 16'h0011, 3'd1, 3'd2, 0, 0, 0, 16'h0011, 16'h00A5, 16'h00A5, 16'h00A5);
        step("wr2", 1, 2'b00, 3'd2, 16'h0022, 3'd1, 3'd2, 0, 0, 0, 16'h0011, 16'h0022, 16'h0011, 16'h00A5);
        idle("dual", 3'd1, 3'd2, 16'h0011, 16'h0022, 16'h0011, 16'h0022);
        idle("same_addr", 3'd2, 3'd2, 16'h0022, 16'h0022, 16'h0022, 16'h0022);

        // Save / restore.
        step("wr0_aaaa", 1, 2'b00, 3'd0, 16'hAAAA, 3'd0, 3'd0, 0, 0, 0, 16'hAAAA, 16'hAAAA, 16'h00A5, 16'h00A5);
        step("save", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 1, 0, 0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        step("save_wr", 1, 2'b00, 3'd0, 16'h5555, 3'd0, 3'd0, 1, 0, 0, 16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA);
        step("wr1_0f0f", 1, 2'b00, 3'd1, 16'h0F0F, 3'd1, 3'd1, 0, 0, 0, 16'h0F0F, 16'h0F0F, 16'h0011, 16'h0011);
        step("restore_wr", 1, 2'b00, 3'd0, 16'h7777, 3'd0, 3'd1, 0, 1, 0, 16'hAAAA, 16'h0011, 16'h5555, 16'h0F0F);
        idle("restore_hold", 3'd0, 3'd1, 16'hAAAA, 16'h0011, 16'hAAAA, 16'h0011);
        step("wr0_2222", 1, 2'b00, 3'd0, 16'h2222, 3'd0, 3'd0, 0, 0, 0, 16'h2222, 16'h2222, 16'hAAAA, 16'hAAAA);
        step("save2", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 1, 0, 0, 16'h2222, 16'h2222, 16'h2222, 16'h2222);
        step("wr0_1111", 1, 2'b00, 3'd0, 16'h1111, 3'd0, 3'd0, 0, 0, 0, 16'h1111, 16'h1111, 16'h2222, 16'h2222);
        step("swap", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 1, 1, 0, 16'h2222, 16'h2222, 16'h1111, 16'h1111);
        idle("swap_hold", 3'd0, 3'd0, 16'h2222, 16'h2222, 16'h2222, 16'h2222);
        step("restore_swapped", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 0, 1, 0, 16'h1111, 16'h1111, 16'h2222, 16'h2222);

        // Out-of-range write and read addresses.
        step("oor_wr7", 1, 2'b00, 3'd7, 16'hDEAD, 3'd6, 3'd7, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step("oor_wr6", 1, 2'b00, 3'd6, 16'hBEEF, 3'd6, 3'd6, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 6; i++)
            idle("bank_sweep", 3'(i), 3'(i), final_vals[i], final_vals[i], final_vals[i], final_vals[i]);

        // Reset discards a same-edge write and save.
        step("reset_mix", 1, 2'b00, 3'd0, 16'h9999, 3'd0, 3'd1, 1, 0, 1, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);
        for (int i = 0; i < 6; i++)
            idle("reset_sweep", 3'(i), 3'(5 - i), 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);
        step("post_rst_wr", 1, 2'b00, 3'd0, 16'h0001, 3'd0, 3'd0, 0, 0, 0, 16'h0001, 16'h0001, 16'h00A5, 16'h00A5);
        step("shadow_reset", 0, 2'b00, 3'd0, 16'h0, 3'd0, 3'd0, 0, 1, 0, 16'h00A5, 16'h00A5, 16'h0001, 16'h0001);

        we = 1'b0; save = 1'b0; restore = 1'b0; reset = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            bad += sb.size();
            total += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
